// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } sup_state_t;

   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
   localparam int DEF_RETRY_MAX           = 3;
   localparam int DEF_GLITCH_CYCLES       = 8;

   localparam int LOST_CNT_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer that releases sys_rst once lock is stable.
// Optional RUN-state lock-loss glitch filter: define PLL_LOCK_GLITCH_FILTER_EN.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int RETRY_MAX           = DEF_RETRY_MAX,
   parameter int GLITCH_CYCLES       = DEF_GLITCH_CYCLES
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  locked,
   output logic                  pll_rst,
   output logic                  sys_rst,
   output logic                  sys_ready,
   output logic                  fault,
   output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

   localparam int MAX_CYC = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                    max_int(LOCK_TIMEOUT_CYCLES, GLITCH_CYCLES));
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int RETRY_W = $clog2(RETRY_MAX + 2);

`ifdef PLL_LOCK_GLITCH_FILTER_EN
   localparam int GLITCH_LEN = GLITCH_CYCLES;
`else
   localparam int GLITCH_LEN = 1;
`endif

   sup_state_t         state;
   sup_state_t         next_state;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic               locked_s;
   logic               timeout;
   logic               lock_loss;
   logic               run_hold;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked),
      .q   (locked_s)
   );

   assign timeout   = (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
   // In RUN the cycle counter tracks consecutive low cycles of locked_s
   assign lock_loss = !locked_s && (cnt == CNT_W'(GLITCH_LEN - 1));
   assign run_hold  = (state == RUN) && (next_state == RUN);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state <= RESET_PLL;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RESET_PLL: begin
            if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               next_state = STABLE;
            end else if (timeout) begin
               next_state = (retry_cnt == RETRY_W'(RETRY_MAX)) ? FAULT : RESET_PLL;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               next_state = WAIT_LOCK;
            end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES)) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (lock_loss) next_state = RESET_PLL;
         end
         FAULT:   next_state = FAULT;
         default: next_state = RESET_PLL;
      endcase
   end

   always_comb begin
      pll_rst = 1'b0;
      fault   = 1'b0;
      case (state)
         RESET_PLL: pll_rst = 1'b1;
         FAULT: begin
            pll_rst = 1'b1;
            fault   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (next_state != state) begin
         cnt <= '0;
      end else begin
         case (state)
            RESET_PLL, WAIT_LOCK, STABLE: cnt <= cnt + CNT_W'(1);
            RUN:     cnt <= locked_s ? '0 : cnt + CNT_W'(1);
            default: cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         retry_cnt <= '0;
      end else if (state == WAIT_LOCK && !locked_s && timeout) begin
         retry_cnt <= retry_cnt + RETRY_W'(1);
      end else if (state == STABLE && next_state == RUN) begin
         retry_cnt <= '0;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_lost_cnt <= '0;
      end else if (state == RUN && next_state == RESET_PLL && lock_lost_cnt != '1) begin
         lock_lost_cnt <= lock_lost_cnt + LOST_CNT_W'(1);
      end
   end

   // Released one cycle after RUN entry, reasserted on the edge that leaves RUN
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sys_rst   <= 1'b1;
         sys_ready <= 1'b0;
      end else begin
         sys_rst   <= !run_hold;
         sys_ready <= run_hold;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (small cycle parameters).
module tb_pll_lock_supervisor;

   localparam int PRC = 4;
   localparam int LSC = 8;
   localparam int LTC = 20;
   localparam int RM  = 2;
   localparam int GC  = 3;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
   localparam int LOSS_LAT = 2 + GC;
`else
   localparam int LOSS_LAT = 3;
`endif

   logic       refclk;
   logic       rst;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       sys_ready;
   logic       fault;
   logic [7:0] lock_lost_cnt;

   int checks = 0;
   int passes = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES      (PRC),
      .LOCK_STABLE_CYCLES  (LSC),
      .LOCK_TIMEOUT_CYCLES (LTC),
      .RETRY_MAX           (RM),
      .GLITCH_CYCLES       (GC)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .locked        (locked),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .sys_ready     (sys_ready),
      .fault         (fault),
      .lock_lost_cnt (lock_lost_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   // Leaves the bench 1 time unit after the edge preceding edge 1 of the new sequence
   task automatic do_reset(input logic lock_val);
      rst    = 1'b1;
      locked = lock_val;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic drop_lock(input int len, output int rst_e, output int pll_e, output int rel_e);
      rst_e  = 0;
      pll_e  = 0;
      rel_e  = 0;
      locked = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         tick(1);
         if (rst_e == 0 && sys_rst === 1'b1) rst_e = e;
         if (pll_e == 0 && pll_rst === 1'b1) pll_e = e;
         if (rst_e != 0 && rel_e == 0 && sys_rst === 1'b0) rel_e = e;
         if (e == len) locked = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      locked = 1'b0;
      tick(3);
      checks++; if (pll_rst !== 1'b1) $display("[TB] FAIL reset_pll_rst: got %b expected 1", pll_rst); else passes++;
      checks++; if (sys_rst !== 1'b1) $display("[TB] FAIL reset_sys_rst: got %b expected 1", sys_rst); else passes++;
      checks++; if (sys_ready !== 1'b0) $display("[TB] FAIL reset_sys_ready: got %b expected 0", sys_ready); else passes++;
      checks++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b expected 0", fault); else passes++;
      checks++; if (lock_lost_cnt !== 8'd0) $display("[TB] FAIL reset_lost_cnt: got %0d expected 0", lock_lost_cnt); else passes++;
   endtask

   task automatic test_power_up();
      int pll_e = 0;
      int rel_e = 0;
      do_reset(1'b1);
      checks++; if (pll_rst !== 1'b1) $display("[TB] FAIL pwrup_pll_rst_start: got %b expected 1", pll_rst); else passes++;
      for (int e = 1; e <= 40; e++) begin
         tick(1);
         if (pll_e == 0 && pll_rst === 1'b0) pll_e = e;
         if (rel_e == 0 && sys_rst === 1'b0) rel_e = e;
      end
      checks++; if (pll_e != PRC) $display("[TB] FAIL pwrup_pll_rst_len: got %0d expected %0d", pll_e, PRC); else passes++;
      checks++; if (rel_e != 15) $display("[TB] FAIL pwrup_sys_rst_release: got %0d expected 15", rel_e); else passes++;
      checks++; if (sys_ready !== 1'b1) $display("[TB] FAIL pwrup_sys_ready: got %b expected 1", sys_ready); else passes++;
      checks++; if (fault !== 1'b0) $display("[TB] FAIL pwrup_fault: got %b expected 0", fault); else passes++;
   endtask

   task automatic test_stable_glitch();
      int rel_e   = 0;
      int pll_hit = 0;
      do_reset(1'b0);
      for (int e = 1; e <= 50; e++) begin
         tick(1);
         if (e >= PRC && pll_rst === 1'b1) pll_hit++;
         if (rel_e == 0 && sys_rst === 1'b0) rel_e = e;
         if (e == 14) locked = 1'b1;
         if (e == 22) locked = 1'b0;
         if (e == 23) locked = 1'b1;
      end
      checks++; if (rel_e != 36) $display("[TB] FAIL glitch_sys_rst_release: got %0d expected 36", rel_e); else passes++;
      checks++; if (pll_hit != 0) $display("[TB] FAIL glitch_no_pll_reset: got %0d expected 0", pll_hit); else passes++;
   endtask

   task automatic test_lock_timeout();
      logic [80:0] obs = '0;
      logic [80:0] exp_v = '0;
      logic        fault_71 = 1'b1;
      logic        fault_72 = 1'b0;
      do_reset(1'b0);
      for (int e = 1; e <= 80; e++) begin
         tick(1);
         obs[e]   = pll_rst;
         exp_v[e] = (e < 4) || (e >= 24 && e < 28) || (e >= 48 && e < 52) || (e >= 72);
         if (e == 71) fault_71 = fault;
         if (e == 72) fault_72 = fault;
      end
      checks++; if (obs !== exp_v) $display("[TB] FAIL timeout_pll_rst_pattern: got %h expected %h", obs, exp_v); else passes++;
      checks++; if (fault_71 !== 1'b0) $display("[TB] FAIL timeout_fault_early: got %b expected 0", fault_71); else passes++;
      checks++; if (fault_72 !== 1'b1) $display("[TB] FAIL timeout_fault_set: got %b expected 1", fault_72); else passes++;
      tick(100);
      checks++; if (fault !== 1'b1) $display("[TB] FAIL timeout_fault_sticky: got %b expected 1", fault); else passes++;
      checks++; if (pll_rst !== 1'b1) $display("[TB] FAIL timeout_pll_rst_held: got %b expected 1", pll_rst); else passes++;
      checks++; if (sys_rst !== 1'b1) $display("[TB] FAIL timeout_sys_rst_held: got %b expected 1", sys_rst); else passes++;
      checks++; if (sys_ready !== 1'b0) $display("[TB] FAIL timeout_sys_ready: got %b expected 0", sys_ready); else passes++;
   endtask

   task automatic test_run_lock_loss();
      int rst_e, pll_e, rel_e;
      do_reset(1'b1);
      tick(20);
      checks++; if (sys_rst !== 1'b0) $display("[TB] FAIL loss_run_reached: got %b expected 0", sys_rst); else passes++;
      for (int n = 1; n <= 3; n++) begin
         drop_lock(5, rst_e, pll_e, rel_e);
         checks++; if (rst_e != LOSS_LAT) $display("[TB] FAIL loss%0d_sys_rst_assert: got %0d expected %0d", n, rst_e, LOSS_LAT); else passes++;
         checks++; if (pll_e != LOSS_LAT) $display("[TB] FAIL loss%0d_pll_rst: got %0d expected %0d", n, pll_e, LOSS_LAT); else passes++;
         checks++; if (rel_e != LOSS_LAT + 15) $display("[TB] FAIL loss%0d_release: got %0d expected %0d", n, rel_e, LOSS_LAT + 15); else passes++;
         checks++; if (lock_lost_cnt !== 8'(n)) $display("[TB] FAIL loss%0d_count: got %0d expected %0d", n, lock_lost_cnt, n); else passes++;
      end
   endtask

   task automatic test_glitch_filter();
      int rst_e, pll_e, rel_e;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
      drop_lock(GC - 1, rst_e, pll_e, rel_e);
      checks++; if (rst_e != 0) $display("[TB] FAIL filter_short_ignored: got %0d expected 0", rst_e); else passes++;
      checks++; if (lock_lost_cnt !== 8'd3) $display("[TB] FAIL filter_short_count: got %0d expected 3", lock_lost_cnt); else passes++;
      drop_lock(GC, rst_e, pll_e, rel_e);
      checks++; if (rst_e != 2 + GC) $display("[TB] FAIL filter_long_react: got %0d expected %0d", rst_e, 2 + GC); else passes++;
      checks++; if (rel_e != 2 + GC + 15) $display("[TB] FAIL filter_long_release: got %0d expected %0d", rel_e, 2 + GC + 15); else passes++;
      checks++; if (lock_lost_cnt !== 8'd4) $display("[TB] FAIL filter_long_count: got %0d expected 4", lock_lost_cnt); else passes++;
`else
      drop_lock(1, rst_e, pll_e, rel_e);
      checks++; if (rst_e != 3) $display("[TB] FAIL single_drop_react: got %0d expected 3", rst_e); else passes++;
      checks++; if (rel_e != 18) $display("[TB] FAIL single_drop_release: got %0d expected 18", rel_e); else passes++;
      checks++; if (lock_lost_cnt !== 8'd4) $display("[TB] FAIL single_drop_count: got %0d expected 4", lock_lost_cnt); else passes++;
`endif
   endtask

   task automatic test_async_reset();
      int rel_e = 0;
      // Mid-RUN with a non-zero loss count left over from the previous scenarios
      #3 rst = 1'b1;
      #1;
      checks++; if (lock_lost_cnt !== 8'd0) $display("[TB] FAIL async_run_lost_cnt: got %0d expected 0", lock_lost_cnt); else passes++;
      checks++; if (sys_ready !== 1'b0) $display("[TB] FAIL async_run_sys_ready: got %b expected 0", sys_ready); else passes++;
      checks++; if (sys_rst !== 1'b1) $display("[TB] FAIL async_run_sys_rst: got %b expected 1", sys_rst); else passes++;
      tick(1);
      do_reset(1'b1);
      tick(8);
      checks++; if (pll_rst !== 1'b0) $display("[TB] FAIL async_stable_pre: got %b expected 0", pll_rst); else passes++;
      #3 rst = 1'b1;
      #1;
      checks++; if (pll_rst !== 1'b1) $display("[TB] FAIL async_stable_pll_rst: got %b expected 1", pll_rst); else passes++;
      tick(1);
      do_reset(1'b0);
      tick(80);
      checks++; if (fault !== 1'b1) $display("[TB] FAIL async_fault_pre: got %b expected 1", fault); else passes++;
      #3 rst = 1'b1;
      #1;
      checks++; if (fault !== 1'b0) $display("[TB] FAIL async_fault_clear: got %b expected 0", fault); else passes++;
      tick(1);
      do_reset(1'b1);
      for (int e = 1; e <= 40; e++) begin
         tick(1);
         if (rel_e == 0 && sys_rst === 1'b0) rel_e = e;
      end
      checks++; if (rel_e != 15) $display("[TB] FAIL async_resequence: got %0d expected 15", rel_e); else passes++;
      checks++; if (sys_ready !== 1'b1) $display("[TB] FAIL async_resequence_ready: got %b expected 1", sys_ready); else passes++;
   endtask

   initial begin
      rst    = 1'b1;
      locked = 1'b0;
      test_reset();
      test_power_up();
      test_stable_glitch();
      test_lock_timeout();
      test_run_lock_loss();
      test_glitch_filter();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
